key_fifo_io: RTL



---
 rtl/key_fifo_io_pkg.sv | 28 ++
 rtl/key_fifo_io_if.sv | 25 ++
 rtl/kf_sync_fifo.sv | 59 +++++
 rtl/key_fifo_io.sv | 131 +++++++++++++
 4 files changed

// File: rtl/key_fifo_io_pkg.sv
// Shared definitions for the keypad code buffer: register offsets, CTRL/DATA
// field positions and the scanner capture FSM state type.
package key_fifo_pkg;

  localparam logic KF_DATA = 1'b0;
  localparam logic KF_CTRL = 1'b1;

  // CTRL read-back bit positions
  localparam int unsigned CTRL_RD_EMPTY  = 0;
  localparam int unsigned CTRL_RD_FULL   = 1;
  localparam int unsigned CTRL_RD_IRQ_EN = 2;
  localparam int unsigned CTRL_RD_OVF    = 3;

  // CTRL write bit positions; irq_en is written on bit1 but reads back on bit2
  localparam int unsigned CTRL_WR_FLUSH   = 0;
  localparam int unsigned CTRL_WR_IRQ_EN  = 1;
  localparam int unsigned CTRL_WR_OVF_CLR = 3;

  localparam int unsigned DATA_CODE_LSB  = 0;
  localparam int unsigned DATA_VALID_BIT = 7;
  localparam int unsigned DATA_COUNT_LSB = 8;

  typedef enum logic [0:0] {
    StIdle,
    StAck
  } cap_state_e;

endpackage

// File: rtl/key_fifo_io_if.sv
// Scanner handshake plus CPU register bus of the key-code buffer.
interface key_fifo_io_if #(
  parameter int unsigned CW = 5
);
  logic          key_ready;
  logic [CW-1:0] key_code;
  logic          readn;
  logic          sel;
  logic          addr;
  logic          we;
  logic          rd;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;

  modport slave (
    input  key_ready, key_code, sel, addr, we, rd, wdata,
    output readn, rdata, irq
  );

  modport master (
    output key_ready, key_code, sel, addr, we, rd, wdata,
    input  readn, rdata, irq
  );
endinterface

// File: rtl/kf_sync_fifo.sv
// Single-clock FIFO with synchronous flush; pushes when full and pops when
// empty are dropped internally. Flush overrides push and pop.
module kf_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 5,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CNTW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [CW-1:0]   i_wdata,
  output logic [CW-1:0]   o_head,
  output logic [CNTW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  logic [CW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/key_fifo_io.sv
// Key-code buffer between keypad scanner and CPU bus: capture FSM, DATA/CTRL
// register decode and pending-key interrupt (enabled by KEY_FIFO_IRQ_EN).
module key_fifo_io
  import key_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 5
) (
  input logic           clk,
  input logic           rst,
  key_fifo_io_if.slave  bus
);

  localparam int unsigned CNTW = $clog2(DEPTH) + 1;

  cap_state_e      r_state;
  logic            r_readn;
  logic            r_ovf;
  logic            w_irq_en;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_ctrl;
  logic            w_flush;
  logic [CW-1:0]   w_head;
  logic [CNTW-1:0] w_count;
  logic [7:0]      w_count8;
  logic            w_full;
  logic            w_empty;
  logic [31:0]     w_rdata;
  logic            w_unused_wdata;

  assign w_push    = (r_state == StIdle) && bus.key_ready && !w_full;
  assign w_pop     = bus.sel && bus.rd && !bus.we && (bus.addr == KF_DATA);
  assign w_wr_ctrl = bus.sel && bus.we && (bus.addr == KF_CTRL);
  assign w_flush   = w_wr_ctrl && bus.wdata[CTRL_WR_FLUSH];
  assign w_count8  = 8'(w_count);
  assign w_unused_wdata = ^{bus.wdata[31:4], bus.wdata[2:1]};

  kf_sync_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (bus.key_code),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // readn stays low until the scanner withdraws key_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_readn <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.key_ready && !w_full) begin
            r_state <= StAck;
            r_readn <= 1'b0;
          end
        end
        StAck: begin
          if (!bus.key_ready) begin
            r_state <= StIdle;
            r_readn <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_readn <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_pop && w_empty) begin
      r_ovf <= 1'b1;
    end else if (w_wr_ctrl && bus.wdata[CTRL_WR_OVF_CLR]) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef KEY_FIFO_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= bus.wdata[CTRL_WR_IRQ_EN];
      r_irq <= r_irq_en && !w_empty;
    end
  end

  assign w_irq_en = r_irq_en;
  assign bus.irq  = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign bus.irq  = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    if (bus.addr == KF_DATA) begin
      w_rdata[DATA_COUNT_LSB +: 8] = w_count8;
      w_rdata[DATA_VALID_BIT]      = !w_empty;
      if (!w_empty) w_rdata[DATA_CODE_LSB +: CW] = w_head;
    end else begin
      w_rdata[7:0]          = w_count8;
      w_rdata[CTRL_RD_EMPTY]  = w_empty;
      w_rdata[CTRL_RD_FULL]   = w_full;
      w_rdata[CTRL_RD_IRQ_EN] = w_irq_en;
      w_rdata[CTRL_RD_OVF]    = r_ovf;
    end
  end

  assign bus.readn = r_readn;
  assign bus.rdata = w_rdata;

endmodule
